// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes and default sizing for the result register.
package alu_pkg;

    localparam int ALU_DATA_W     = 8;
    localparam int ALU_HIST_DEPTH = 4;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0,
        ALU_SUB    = 3'd1,
        ALU_AND    = 3'd2,
        ALU_OR     = 3'd3,
        ALU_XOR    = 3'd4,
        ALU_PASS_A = 3'd5,
        ALU_PASS_B = 3'd6,
        ALU_NOP    = 3'd7
    } alu_op_e;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a synchronised level input; reset preloads the history
// to 1 so a level already high at reset release is not taken as an edge.
module edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic prev_btn_q;
    logic prev_btn_d;

    always_comb begin
        prev_btn_d = btn;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_btn_q <= 1'b1;
        end else begin
            prev_btn_q <= prev_btn_d;
        end
    end

    assign rise = btn & ~prev_btn_q;

endmodule

// File: rtl/alu_result_reg.sv
// ALU result register: captures alu_in on each load-button press, keeps a short
// circular history of captured words, and counts accepted loads.
module alu_result_reg
    import alu_pkg::*;
#(
    parameter int DATA_W     = ALU_DATA_W,
    parameter int HIST_DEPTH = ALU_HIST_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             alu_in,
    input  logic                          load_btn,
    input  logic                          clear,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_sel,
    output logic [DATA_W-1:0]             acc,
    output logic [3:0]                    b_fb,
    output logic [DATA_W-1:0]             hist_out,
    output logic [$clog2(HIST_DEPTH):0]   hist_count,
    output logic [7:0]                    load_count,
    output logic                          changed
);

    localparam int                PTR_W    = $clog2(HIST_DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(HIST_DEPTH);
    localparam logic [7:0]        LC_MAX   = 8'hFF;

    logic                    rise;
    logic [DATA_W-1:0]       acc_q, acc_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]        hist_count_q, hist_count_d;
    logic [7:0]              load_count_q, load_count_d;
    logic                    changed_q, changed_d;
    logic [DATA_W-1:0]       hist_q [HIST_DEPTH];
    logic [DATA_W-1:0]       hist_d [HIST_DEPTH];
    logic [PTR_W-1:0]        rd_idx;

    edge_detect u_edge (
        .clock (clock),
        .reset (reset),
        .btn   (load_btn),
        .rise  (rise)
    );

    // Clear wins over a coincident press; that press is dropped entirely.
    always_comb begin
        acc_d        = acc_q;
        wr_ptr_d     = wr_ptr_q;
        hist_count_d = hist_count_q;
        load_count_d = load_count_q;
        changed_d    = 1'b0;
        hist_d       = hist_q;
        if (clear) begin
            acc_d        = '0;
            wr_ptr_d     = '0;
            hist_count_d = '0;
            load_count_d = '0;
        end else if (rise) begin
            acc_d            = alu_in;
            changed_d        = (alu_in != acc_q);
            hist_d[wr_ptr_q] = alu_in;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            if (hist_count_q != CNT_FULL) begin
                hist_count_d = hist_count_q + CNT_W'(1);
            end
            if (load_count_q != LC_MAX) begin
                load_count_d = load_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q        <= '0;
            wr_ptr_q     <= '0;
            hist_count_q <= '0;
            load_count_q <= '0;
            changed_q    <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            wr_ptr_q     <= wr_ptr_d;
            hist_count_q <= hist_count_d;
            load_count_q <= load_count_d;
            changed_q    <= changed_d;
        end
    end

    // History storage is data only and is never reset.
    always_ff @(posedge clock) begin
        hist_q <= hist_d;
    end

    assign rd_idx     = wr_ptr_q - PTR_W'(1) - hist_sel;
    assign hist_out   = ({1'b0, hist_sel} < hist_count_q) ? hist_q[rd_idx] : '0;
    assign acc        = acc_q;
    assign b_fb       = acc_q[3:0];
    assign hist_count = hist_count_q;
    assign load_count = load_count_q;
    assign changed    = changed_q;

endmodule

// File: tb/tb_alu_result_reg.sv
// Self-checking bench for alu_result_reg: table-driven load vectors with a scoreboard
// of expected captures, plus directed sequences for clear, reset and saturation.
module tb_alu_result_reg;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] alu_in;
    logic       load_btn;
    logic       clear;
    logic [1:0] hist_sel;
    logic [7:0] acc;
    logic [3:0] b_fb;
    logic [7:0] hist_out;
    logic [2:0] hist_count;
    logic [7:0] load_count;
    logic       changed;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] acc;
        logic       chg;
    } exp_t;

    typedef struct {
        logic [7:0] din;
        logic [2:0] exp_cnt;
        logic [7:0] exp_lc;
    } vec_t;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] exp_out;
    } hvec_t;

    exp_t       sb[$];
    logic [7:0] m_acc;
    int         m_lc;
    int         m_hc;

    alu_result_reg dut (
        .clock      (clock),
        .reset      (reset),
        .alu_in     (alu_in),
        .load_btn   (load_btn),
        .clear      (clear),
        .hist_sel   (hist_sel),
        .acc        (acc),
        .b_fb       (b_fb),
        .hist_out   (hist_out),
        .hist_count (hist_count),
        .load_count (load_count),
        .changed    (changed)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_acc = 8'h00;
        m_lc  = 0;
        m_hc  = 0;
    endtask

    task automatic sb_check();
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_empty actual=0 required=1");
        end else begin
            total--;
            e = sb.pop_front();
            chk("sb_acc", acc, e.acc);
            chk("sb_changed", changed, e.chg);
            chk("sb_b_fb", b_fb, e.acc[3:0]);
            chk("sb_load_count", load_count, m_lc);
            chk("sb_hist_count", hist_count, m_hc);
        end
    endtask

    // One press: button rises for one cycle with v on alu_in, then releases.
    task automatic load_word(input logic [7:0] v);
        exp_t e;
        alu_in   = v;
        load_btn = 1'b1;
        e.acc    = v;
        e.chg    = (v != m_acc);
        sb.push_back(e);
        m_acc = v;
        if (m_lc != 255) m_lc++;
        if (m_hc != 4) m_hc++;
        step();
        sb_check();
        load_btn = 1'b0;
        step();
        chk("changed_one_cycle", changed, 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_clear();
    endtask

    vec_t  vecs[5];
    hvec_t hvecs[4];

    initial begin
        vecs[0] = '{8'h01, 3'd1, 8'd1};
        vecs[1] = '{8'h02, 3'd2, 8'd2};
        vecs[2] = '{8'h03, 3'd3, 8'd3};
        vecs[3] = '{8'h04, 3'd4, 8'd4};
        vecs[4] = '{8'h05, 3'd4, 8'd5};
        hvecs[0] = '{2'd0, 8'h05};
        hvecs[1] = '{2'd1, 8'h04};
        hvecs[2] = '{2'd2, 8'h03};
        hvecs[3] = '{2'd3, 8'h02};

        reset = 1'b1; clear = 1'b0; load_btn = 1'b0; alu_in = 8'h00; hist_sel = 2'd0;
        model_clear();
        step();
        step();
        chk("rst_acc", acc, 0);
        chk("rst_hist_count", hist_count, 0);
        chk("rst_load_count", load_count, 0);
        chk("rst_changed", changed, 0);
        chk("rst_b_fb", b_fb, 0);
        chk("rst_hist_out", hist_out, 0);
        reset = 1'b0;
        step();

        // Single press held for five cycles.
        alu_in   = 8'h3C;
        load_btn = 1'b1;
        chk("pre_edge_acc", acc, 0);
        sb.push_back('{8'h3C, 1'b1});
        m_acc = 8'h3C; m_lc = 1; m_hc = 1;
        step();
        sb_check();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("held_changed", changed, 0);
            chk("held_load_count", load_count, 1);
            chk("held_acc", acc, 8'h3C);
        end
        load_btn = 1'b0;
        step();

        do_clear();
        chk("clr_acc", acc, 0);
        chk("clr_load_count", load_count, 0);
        chk("clr_hist_count", hist_count, 0);

        for (int i = 0; i < 5; i++) begin
            load_word(vecs[i].din);
            chk("vec_hist_count", hist_count, vecs[i].exp_cnt);
            chk("vec_load_count", load_count, vecs[i].exp_lc);
        end
        for (int i = 0; i < 4; i++) begin
            hist_sel = hvecs[i].sel;
            #1;
            chk("hist_out_wrap", hist_out, hvecs[i].exp_out);
        end

        // Identical words: only the first one reports a change.
        do_clear();
        load_word(8'hA5);
        load_word(8'hA5);
        chk("dup_hist_count", hist_count, 2);
        hist_sel = 2'd2; #1;
        chk("hist_out_invalid", hist_out, 0);
        hist_sel = 2'd1; #1;
        chk("hist_out_sel1", hist_out, 8'hA5);
        hist_sel = 2'd0;

        // Press coincident with clear is discarded, and holding across clear gives no load.
        alu_in   = 8'h77;
        load_btn = 1'b1;
        clear    = 1'b1;
        step();
        clear = 1'b0;
        model_clear();
        chk("clrld_acc", acc, 0);
        chk("clrld_load_count", load_count, 0);
        chk("clrld_hist_count", hist_count, 0);
        chk("clrld_changed", changed, 0);
        step();
        step();
        chk("clrhold_acc", acc, 0);
        chk("clrhold_load_count", load_count, 0);
        load_btn = 1'b0;
        step();

        // Button held through reset release.
        load_btn = 1'b1;
        alu_in   = 8'h99;
        reset    = 1'b1;
        step();
        step();
        reset = 1'b0;
        model_clear();
        step();
        step();
        chk("rsthold_acc", acc, 0);
        chk("rsthold_load_count", load_count, 0);
        chk("rsthold_changed", changed, 0);
        load_btn = 1'b0;
        step();
        load_word(8'h99);
        chk("after_rel_acc", acc, 8'h99);

        // Load counter saturation.
        do_clear();
        for (int i = 0; i < 260; i++) begin
            load_word(8'(i) ^ 8'h5A);
        end
        chk("sat_load_count", load_count, 255);
        chk("sat_acc", acc, 8'(259) ^ 8'h5A);
        chk("sat_hist_count", hist_count, 4);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_reg.md
ALU_RESULT_REG -- requirements
Module: alu_result_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of captured ALU result.
REQ-002 SHALL have parameter HIST_DEPTH, default 4, number of history entries (power of two, 2..16).
REQ-003 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port alu_in  input  DATA_W  result word from upstream ALU.
REQ-006 SHALL have port load_btn  input  1  level load request (pushbutton-style, already synchronised).
REQ-007 SHALL have port clear  input  1  synchronous clear of accumulator and history.
REQ-008 SHALL have port hist_sel  input  log2(HIST_DEPTH)  history read index, 0 = most recent.
REQ-009 SHALL have port acc  output  DATA_W  registered accumulator value.
REQ-010 SHALL have port b_fb  output  4  feedback operand to ALU B input, equal to acc[3:0].
REQ-011 SHALL have port hist_out  output  DATA_W  selected history entry.
REQ-012 SHALL have port hist_count  output  log2(HIST_DEPTH)+1  valid history entries.
REQ-013 SHALL have port load_count  output  8  number of accepted loads, saturating.
REQ-014 SHALL have port changed  output  1  one-cycle pulse: last load altered acc.

Function
REQ-015 SHALL register load_btn into prev_btn each cycle; load event = load_btn & ~prev_btn.
REQ-016 SHALL, on a load event, capture alu_in into acc at that same clock edge (acc valid next cycle).
REQ-017 SHALL accept at most one load per rising level of load_btn; holding load_btn high SHALL NOT reload.
REQ-018 SHALL, on a load event, write alu_in to hist[wr_ptr] and advance wr_ptr modulo HIST_DEPTH (wrap overwrites oldest).
REQ-019 SHALL increment hist_count per load, saturating at HIST_DEPTH.
REQ-020 SHALL increment load_count per load, saturating at 255 (no wrap to 0).
REQ-021 SHALL drive hist_out combinationally as hist[(wr_ptr-1-hist_sel) mod HIST_DEPTH] when hist_sel < hist_count, else all zero.
REQ-022 SHALL assert changed for exactly the one cycle after a load edge where alu_in differed from prior acc; otherwise 0.
REQ-023 SHALL, when clear=1, set acc, hist_count, wr_ptr, load_count, changed to 0 at next edge; history storage contents need not be cleared.
REQ-024 SHALL give clear priority over a simultaneous load event; that load is discarded and not counted.
REQ-025 SHALL still update prev_btn during clear, so a button held across clear produces no load after clear releases.
REQ-026 SHALL keep b_fb = acc[3:0] at all times, no extra latency.

Reset
REQ-027 SHALL, while reset=1 at a clock edge, set acc=0, hist_count=0, wr_ptr=0, load_count=0, changed=0.
REQ-028 SHALL set prev_btn=1 during reset so a button held through reset release causes no load.
REQ-029 SHALL give reset priority over clear and load.

Structure
REQ-030 SHALL take DATA_W default and HIST_DEPTH default from shared package alu_pkg, alongside the ALU function-code constants.
REQ-031 SHALL place the rising-edge detector (REQ-015, REQ-028) in sub-module edge_detect; all else in alu_result_reg.
REQ-032 SHALL implement history as a register array indexed by wr_ptr, no RAM inference required.

Verification
REQ-033 SHALL cover: reset, alu_in=8'h3C, load_btn 0->1 held 5 cycles -> acc=8'h3C one cycle later, load_count=1, b_fb=4'hC, changed pulse 1 cycle.
REQ-034 SHALL cover: loads of 8'h01,02,03,04,05 (HIST_DEPTH=4) -> hist_count=4, hist_sel 0..3 = 05,04,03,02.
REQ-035 SHALL cover: load_btn rising same cycle as clear=1 -> acc=0, load_count=0, hist_count=0, changed=0.
REQ-036 SHALL cover: load_btn held high through reset release -> no load until load_btn falls and rises again.
REQ-037 SHALL cover: two loads of identical 8'hA5 -> changed pulses on first only; hist_sel=2 with hist_count=2 -> hist_out=0.
REQ-038 SHALL cover: 260 load edges -> load_count stays 255, acc equals last alu_in.
